// File: rtl/hazard_detect_id_if.sv
// Decode-stage hazard interface: ID/EX/MEM register info in, stall and forwarding controls out.
interface hazard_detect_id_if;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       uses_rt_id;
  logic       branch_id;
  logic       taken_id;
  logic [4:0] towrite_ex;
  logic       regwrite_ex;
  logic       memread_ex;
  logic [4:0] towrite_mem;
  logic       regwrite_mem;
  logic       memread_mem;
  logic       pc_we;
  logic       ifid_we;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       lw_stall_ex;
  logic       branch_stall_forwarding;

  modport master (
    output rs_id, rt_id, uses_rt_id, branch_id, taken_id,
    output towrite_ex, regwrite_ex, memread_ex,
    output towrite_mem, regwrite_mem, memread_mem,
    input  pc_we, ifid_we, ifid_flush, idex_bubble,
    input  lw_stall_ex, branch_stall_forwarding
  );

  modport slave (
    input  rs_id, rt_id, uses_rt_id, branch_id, taken_id,
    input  towrite_ex, regwrite_ex, memread_ex,
    input  towrite_mem, regwrite_mem, memread_mem,
    output pc_we, ifid_we, ifid_flush, idex_bubble,
    output lw_stall_ex, branch_stall_forwarding
  );
endinterface

// File: rtl/hazard_detect_id.sv
// ID-stage hazard detection: load-use and branch-operand stalls, EX forwarding controls.
// Optional saturating stall counter enabled by defining HAZARD_PERF_EN.
module hazard_detect_id #(
  parameter int unsigned PERF_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       uses_rt_id,
  input  logic       branch_id,
  input  logic       taken_id,
  input  logic [4:0] towrite_ex,
  input  logic       regwrite_ex,
  input  logic       memread_ex,
  input  logic [4:0] towrite_mem,
  input  logic       regwrite_mem,
  input  logic       memread_mem,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       lw_stall_ex,
  output logic       branch_stall_forwarding
`ifdef HAZARD_PERF_EN
  , output logic [PERF_W-1:0] stall_count
`endif
);

  typedef enum logic {IDLE, BR_LW2} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_lu_sr;
  logic       r_bsf;

  logic w_ex_match, w_mem_match;
  logic w_lu, w_bl, w_ba;
  logic w_stall, w_lu_stall, w_br_stall;

  always_comb begin
    w_ex_match  = (regwrite_ex && (rs_id != '0) && (rs_id == towrite_ex)) ||
                  (regwrite_ex && uses_rt_id && (rt_id != '0) && (rt_id == towrite_ex));
    w_mem_match = (regwrite_mem && (rs_id != '0) && (rs_id == towrite_mem)) ||
                  (regwrite_mem && uses_rt_id && (rt_id != '0) && (rt_id == towrite_mem));
    w_lu = memread_ex && w_ex_match && !branch_id;
    w_bl = branch_id && memread_ex && w_ex_match;
    w_ba = branch_id && ((w_ex_match && !memread_ex) || (w_mem_match && memread_mem));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_bl) w_state_nxt = BR_LW2;
      BR_LW2:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Held reset forces the pass-through outputs even if inputs present a hazard.
  always_comb begin
    w_lu_stall = 1'b0;
    w_br_stall = 1'b0;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          if (w_bl || w_ba) w_br_stall = 1'b1;
          else if (w_lu)    w_lu_stall = 1'b1;
        end
        BR_LW2:  w_br_stall = 1'b1;
        default: w_br_stall = 1'b0;
      endcase
    end
    w_stall     = w_lu_stall || w_br_stall;
    pc_we       = !w_stall;
    ifid_we     = !w_stall;
    idex_bubble = w_stall;
    ifid_flush  = rst_n && taken_id && !w_stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_sr <= '0;
      r_bsf   <= 1'b0;
    end else begin
      r_lu_sr <= {r_lu_sr[0], w_lu_stall};
      r_bsf   <= w_br_stall;
    end
  end

  assign lw_stall_ex             = r_lu_sr[1];
  assign branch_stall_forwarding = r_bsf;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule
